// File: rtl/fft_frame_streamer.sv
// fft_frame_streamer
// Captures one parallel FFT result frame (D_WIDTH samples of S_WIDTH bits,
// sample i at frame_in[S_WIDTH*i +: S_WIDTH]) and streams it out one sample
// per beat over a valid/ready interface. Optional bit-reversed readout turns
// radix-2 output order into natural frequency order.
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   frame_in     packed frame from the fft output bus
//   frame_valid  frame_in holds a complete frame
//   frame_ready  block can accept a frame this cycle
//   m_data       current sample
//   m_valid      m_data / m_index / m_last are valid
//   m_ready      downstream accepts the current beat
//   m_index      frame slot of the current sample
//   m_last       current beat is the final beat of the frame
//   busy         a frame is held and being streamed
//   frame_count  completed frames, wraps 0xFFFF -> 0
module fft_frame_streamer #(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6,
  parameter int S_WIDTH     = 16,
  parameter bit BIT_REV     = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [S_WIDTH*D_WIDTH-1:0] frame_in,
  input  logic                       frame_valid,
  output logic                       frame_ready,
  output logic [S_WIDTH-1:0]         m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [LOG_2_WIDTH-1:0]     m_index,
  output logic                       m_last,
  output logic                       busy,
  output logic [15:0]                frame_count
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [LOG_2_WIDTH-1:0] LAST_COUNT = LOG_2_WIDTH'(D_WIDTH - 1);

  state_t                   state_q;
  logic [LOG_2_WIDTH-1:0]   count_q;
  logic [S_WIDTH-1:0]       buf_q [D_WIDTH];
  logic [15:0]              frame_count_q;
  logic [15:0]              frame_count_d;
  logic                     frame_ready_q;
  logic                     busy_q;
  logic                     m_valid_q;

  logic [LOG_2_WIDTH-1:0]   count_rev;
  logic [LOG_2_WIDTH-1:0]   addr;
  logic                     is_last;
  logic                     capture;

  // Mirror the beat counter bit by bit for radix-2 reordering.
  genvar gi;
  generate
    for (gi = 0; gi < LOG_2_WIDTH; gi++) begin : g_rev
      assign count_rev[gi] = count_q[LOG_2_WIDTH-1-gi];
    end
  endgenerate

  assign addr          = BIT_REV ? count_rev : count_q;
  assign is_last       = (count_q == LAST_COUNT);
  assign capture       = (state_q == IDLE) && frame_valid;
  assign frame_count_d = frame_count_q + 16'd1;

  // Control FSM. Status outputs are registered alongside the state so no
  // input reaches an output combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      frame_count_q <= '0;
      frame_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      m_valid_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_valid) begin
            state_q       <= STREAM;
            count_q       <= '0;
            frame_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            m_valid_q     <= 1'b1;
          end
        end
        STREAM: begin
          // m_valid is always high in STREAM, so m_ready alone marks a transfer.
          if (m_ready) begin
            if (is_last) begin
              state_q       <= IDLE;
              count_q       <= '0;
              frame_count_q <= frame_count_d;
              frame_ready_q <= 1'b1;
              busy_q        <= 1'b0;
              m_valid_q     <= 1'b0;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Frame buffer: loaded only on acceptance, so later changes on frame_in
  // cannot leak into a frame that is being streamed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D_WIDTH; i++) begin
        buf_q[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < D_WIDTH; i++) begin
        buf_q[i] <= frame_in[S_WIDTH*i +: S_WIDTH];
      end
    end
  end

  // Beat outputs are decoded from registered state only; forced to zero when
  // no beat is offered so reset and idle present clean values.
  assign m_data      = m_valid_q ? buf_q[addr] : '0;
  assign m_index     = m_valid_q ? addr : '0;
  assign m_last      = m_valid_q && is_last;
  assign m_valid     = m_valid_q;
  assign frame_ready = frame_ready_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fft_frame_streamer.sv
module tb_fft_frame_streamer;

  localparam int D = 64;
  localparam int L = 6;
  localparam int S = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [S*D-1:0] frame_in = '0;
  logic         frame_valid = 1'b0;
  logic         m_ready = 1'b0;

  logic         n_frame_ready, n_valid, n_last, n_busy;
  logic [S-1:0] n_data;
  logic [L-1:0] n_index;
  logic [15:0]  n_fc;
  logic         r_frame_ready, r_valid, r_last, r_busy;
  logic [S-1:0] r_data;
  logic [L-1:0] r_index;
  logic [15:0]  r_fc;

  always #5 clk = ~clk;

  fft_frame_streamer #(.D_WIDTH(D), .LOG_2_WIDTH(L), .S_WIDTH(S), .BIT_REV(1'b0)) dut_n (
    .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(frame_valid),
    .frame_ready(n_frame_ready), .m_data(n_data), .m_valid(n_valid),
    .m_ready(m_ready), .m_index(n_index), .m_last(n_last), .busy(n_busy),
    .frame_count(n_fc)
  );

  fft_frame_streamer #(.D_WIDTH(D), .LOG_2_WIDTH(L), .S_WIDTH(S), .BIT_REV(1'b1)) dut_r (
    .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(frame_valid),
    .frame_ready(r_frame_ready), .m_data(r_data), .m_valid(r_valid),
    .m_ready(m_ready), .m_index(r_index), .m_last(r_last), .busy(r_busy),
    .frame_count(r_fc)
  );

  typedef struct packed {
    logic [S-1:0] data;
    logic [L-1:0] index;
    logic         last;
  } beat_t;

  beat_t q_n[$];
  beat_t q_r[$];

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int bitrev(input int v);
    int r;
    r = 0;
    for (int b = 0; b < L; b++) begin
      if (v[b]) r = r | (1 << (L - 1 - b));
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a frame with slot i = base + i*step and queue the expected beats
  // for both readout orders.
  task automatic load_frame(input int base, input int step);
    int a;
    for (int i = 0; i < D; i++) frame_in[S*i +: S] = S'(base + i * step);
    for (int c = 0; c < D; c++) begin
      a = bitrev(c);
      q_n.push_back('{data: S'(base + c * step), index: L'(c), last: (c == D - 1)});
      q_r.push_back('{data: S'(base + a * step), index: L'(a), last: (c == D - 1)});
    end
  endtask

  // Full-rate stream: a beat is offered every cycle, then one idle cycle.
  task automatic stream_full(input string tag);
    for (int k = 0; k < D; k++) begin
      check({tag, "_valid"}, {n_valid, r_valid}, 2'b11);
      check({tag, "_frame_ready_low"}, {n_frame_ready, r_frame_ready}, 2'b00);
      tick();
    end
    check({tag, "_frame_ready_back"}, {n_frame_ready, r_frame_ready}, 2'b11);
    check({tag, "_valid_idle"}, {n_valid, r_valid, n_busy, r_busy}, 4'b0000);
  endtask

  // Monitors: pop an expected beat on every transfer; check data hold under stall.
  logic         hold_n = 1'b0;
  logic [S-1:0] hd_n;
  logic [L-1:0] hi_n;
  always @(negedge clk) begin
    beat_t e;
    if (hold_n && !rst) begin
      check("n_hold_data", n_data, hd_n);
      check("n_hold_index", n_index, hi_n);
    end
    if (n_valid && m_ready && !rst) begin
      if (q_n.size() == 0) check("n_unexpected_beat", 1, 0);
      else begin
        e = q_n.pop_front();
        check("n_data", n_data, e.data);
        check("n_index", n_index, e.index);
        check("n_last", n_last, e.last);
      end
    end
    hold_n = n_valid && !m_ready && !rst;
    hd_n   = n_data;
    hi_n   = n_index;
  end

  logic         hold_r = 1'b0;
  logic [S-1:0] hd_r;
  logic [L-1:0] hi_r;
  always @(negedge clk) begin
    beat_t e;
    if (hold_r && !rst) begin
      check("r_hold_data", r_data, hd_r);
      check("r_hold_index", r_index, hi_r);
    end
    if (r_valid && m_ready && !rst) begin
      if (q_r.size() == 0) check("r_unexpected_beat", 1, 0);
      else begin
        e = q_r.pop_front();
        check("r_data", r_data, e.data);
        check("r_index", r_index, e.index);
        check("r_last", r_last, e.last);
      end
    end
    hold_r = r_valid && !m_ready && !rst;
    hd_r   = r_data;
    hi_r   = r_index;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;

    // Reset with frame_valid asserted: nothing may be captured.
    rst = 1'b1;
    frame_valid = 1'b1;
    frame_in = {D{16'hABCD}};
    m_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", {n_valid, r_valid}, 2'b00);
    check("rst_frame_ready", {n_frame_ready, r_frame_ready}, 2'b11);
    check("rst_busy", {n_busy, r_busy}, 2'b00);
    check("rst_data", {n_data, r_data}, 32'h0);
    check("rst_index_last", {n_index, r_index, n_last, r_last}, 14'h0);
    check("rst_frame_count", {n_fc, r_fc}, 32'h0);
    rst = 1'b0;
    frame_valid = 1'b0;
    tick();
    check("post_rst_idle", {n_valid, r_valid, n_busy, r_busy}, 4'b0000);

    // Natural / bit-reversed order at full rate, slot i = i.
    m_ready = 1'b1;
    load_frame(0, 1);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    stream_full("order");
    check("order_frame_count", {n_fc, r_fc}, {16'd1, 16'd1});

    // Backpressure with input overwritten after capture.
    load_frame(16'h0400, 7);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    frame_in = {D{16'hFFFF}};
    cycles = 0;
    while ((n_busy || r_busy) && cycles < 2000) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
      cycles++;
    end
    check("bp_done_in_budget", (cycles < 2000), 1);
    m_ready = 1'b1;
    check("bp_frame_count", {n_fc, r_fc}, {16'd2, 16'd2});

    // Asynchronous reset mid-stream after beat 20.
    load_frame(0, 3);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    repeat (21) tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid_async", {n_valid, r_valid}, 2'b00);
    check("midrst_frame_ready", {n_frame_ready, r_frame_ready}, 2'b11);
    check("midrst_busy", {n_busy, r_busy}, 2'b00);
    q_n.delete();
    q_r.delete();
    tick();
    rst = 1'b0;
    check("midrst_frame_count", {n_fc, r_fc}, 32'h0);
    load_frame(16'h100, 1);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    stream_full("post_rst");
    check("post_rst_frame_count", {n_fc, r_fc}, {16'd1, 16'd1});

    // Back-to-back frames with frame_count wrap.
    force dut_n.frame_count_q = 16'hFFFE;
    force dut_r.frame_count_q = 16'hFFFE;
    #1;
    release dut_n.frame_count_q;
    release dut_r.frame_count_q;
    check("wrap_preload", {n_fc, r_fc}, {16'hFFFE, 16'hFFFE});
    load_frame(16'h2000, 1);
    frame_valid = 1'b1;
    tick();
    stream_full("b2b_a");
    check("b2b_a_frame_count", {n_fc, r_fc}, {16'hFFFF, 16'hFFFF});
    load_frame(16'h3000, 2);
    tick();
    frame_valid = 1'b0;
    check("b2b_b_accepted", {n_valid, r_valid}, 2'b11);
    stream_full("b2b_b");
    check("wrap_frame_count", {n_fc, r_fc}, 32'h0);

    repeat (3) tick();
    check("queue_n_empty", q_n.size(), 0);
    check("queue_r_empty", q_r.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fft_frame_streamer.md
Name: fft_frame_streamer

Overview:
Output-side companion to the fft core. It captures one complete parallel FFT result frame, which is D_WIDTH samples of S_WIDTH bits packed flat with sample i at bits [S_WIDTH*i + S_WIDTH-1 : S_WIDTH*i]. It then streams the frame out one sample per beat over a valid/ready interface. Optional bit-reversed readout reorders radix-2 output into natural frequency order. It sits between the fft output_sig bus and downstream serial consumers (DMA, UART bridge, scan-out).

Parameters:
D_WIDTH, 64, number of samples per frame (power of two, >= 2)
LOG_2_WIDTH, 6, log2(D_WIDTH); width of beat counter and index
S_WIDTH, 16, bits per sample
BIT_REV, 1, 1 = read slot bitrev(count); 0 = read slot count

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
frame_in  input  S_WIDTH*D_WIDTH  packed frame from fft output_sig
frame_valid  input  1  frame_in holds a complete frame
frame_ready  output  1  block can accept a frame this cycle
m_data  output  S_WIDTH  current sample
m_valid  output  1  m_data/m_index/m_last valid
m_ready  input  1  downstream accepts beat
m_index  output  LOG_2_WIDTH  frame slot of current sample
m_last  output  1  current beat is final beat of frame
busy  output  1  frame held / streaming
frame_count  output  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Reset (async assert, any state): state=IDLE, count=0, frame buffer=0, frame_count=0. Outputs go immediately to m_valid=0, m_last=0, m_data=0, m_index=0, busy=0, frame_ready=1.
- States: IDLE, STREAM.
- IDLE: frame_ready=1, m_valid=0, busy=0. On an edge with frame_valid=1, register frame_in into the internal buffer, set count=0 and go to STREAM. frame_valid is not checked while in STREAM.
- STREAM: frame_ready=0, busy=1, m_valid=1.
- Readout: addr = BIT_REV ? bit-reverse(count) over LOG_2_WIDTH bits : count. m_data = buffer slot addr, m_index = addr, m_last = (count == D_WIDTH-1). All three are decoded from registered state, so they are stable while m_valid=1 and m_ready=0.
- Transfer = m_valid && m_ready at a rising edge. On a transfer with count<D_WIDTH-1: count+1. On a transfer with count==D_WIDTH-1: go to IDLE, count=0, frame_count+1 (modulo 2^16).
- Timing: frame accepted at edge N. Beat 0 is visible after edge N. With m_ready held at 1, beats transfer at edges N+1..N+D_WIDTH. frame_ready returns high after edge N+D_WIDTH. The next frame can be accepted at edge N+D_WIDTH+1 at the earliest, so back-to-back frames leave exactly one idle cycle.
- Buffer isolation: changes on frame_in after capture never affect streamed data.
- No beat is skipped or duplicated under any m_ready pattern.
- m_ready is ignored while m_valid=0.
- Reset mid-stream discards the current frame. frame_count does not increment for it.
- Combinational paths: none from inputs to outputs, except the async reset path.

Test Plan:
- Reset: assert rst for 2 cycles with frame_valid=1 -> m_valid=0, frame_ready=1, busy=0, m_data=0, frame_count=0, and no frame is captured while rst=1.
- Natural order (BIT_REV=0): frame slot i = i, m_ready=1 -> m_data 0,1,...,63 on consecutive cycles; m_index=m_data; m_last only on beat 63; frame_count=1; frame_ready high the cycle after beat 63.
- Bit-reversed order (BIT_REV=1): same frame -> m_data sequence 0,32,16,48,8,40,... ending 31,63; m_last on value 63; m_index equals m_data each beat.
- Backpressure: m_ready pseudo-random with ~50% duty, and frame_in overwritten with 0xFFFF in every slot after capture -> m_data is held constant while m_ready=0; all 64 original values arrive exactly once, in order; no 0xFFFF appears.
- Reset mid-operation: assert rst asynchronously between edges after beat 20 -> m_valid falls before the next edge; after release, a new frame with slot i = 0x100+i streams starting at index 0; frame_count=0.
- Back-to-back and wrap: frame_valid held high with frame_count preloaded via 65535 frames (or forced) -> one idle cycle between frames; frame_count goes 0xFFFF -> 0x0000 at the end of the next frame.
